redmule_pwr_ctrl: RTL and testbench
===================================

REDMULE_PWR_CTRL -- requirements
Module: redmule_pwr_ctrl

Interface
REQ-001 SHALL have parameter WAKE_CYCLES, default 2: number of cycles the accelerator clock runs before offload is permitted (legal range 1..255).
REQ-002 SHALL have parameter IDLE_CYCLES, default 16: number of consecutive idle cycles in ACTIVE before the clock is gated (legal range 1..255).
REQ-003 SHALL have port clk_i, input, 1: the single clock, ungated system clock.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port fetch_enable_i, input, 1: global enable for accelerator use.
REQ-006 SHALL have port req_valid_i, input, 1: offload request from the core issue side.
REQ-007 SHALL have port req_ready_o, output, 1: offload request accepted.
REQ-008 SHALL have port acc_valid_o, output, 1: offload request forwarded to the accelerator.
REQ-009 SHALL have port acc_ready_i, input, 1: accelerator accepts the forwarded request.
REQ-010 SHALL have port acc_busy_i, input, 1: accelerator busy.
REQ-011 SHALL have port clk_en_o, output, 1: enable to the accelerator clock gate.
REQ-012 SHALL have port busy_o, output, 1: controller not in SLEEP.
REQ-013 SHALL have port state_o, output, 2: current state encoding (SLEEP=0, WAKE=1, ACTIVE=2, DRAIN=3).

Function
REQ-014 SHALL implement a registered FSM with states SLEEP, WAKE, ACTIVE, DRAIN; all outputs are combinational decodes of the state plus the inputs listed below.
REQ-015 SHALL drive clk_en_o=1 in WAKE, ACTIVE and DRAIN, and 0 in SLEEP.
REQ-016 SHALL drive busy_o=1 when state!=SLEEP.
REQ-017 SHALL, in ACTIVE only, drive acc_valid_o=req_valid_i and req_ready_o=acc_ready_i; in every other state both are 0.
REQ-018 SHALL move SLEEP->WAKE when req_valid_i=1 and fetch_enable_i=1, loading the wake counter with WAKE_CYCLES-1; otherwise stay in SLEEP.
REQ-019 SHALL, in WAKE, decrement the wake counter each cycle and move WAKE->ACTIVE in the cycle after the counter reads 0, so WAKE lasts exactly WAKE_CYCLES cycles.
REQ-020 SHALL move WAKE->SLEEP if fetch_enable_i=0 in any WAKE cycle (priority over the counter).
REQ-021 SHALL, in ACTIVE, clear the idle counter on entry and in any cycle with req_valid_i=1 or acc_busy_i=1, and increment it otherwise.
REQ-022 SHALL move ACTIVE->SLEEP when the idle counter equals IDLE_CYCLES-1 and the current cycle is idle, i.e. after exactly IDLE_CYCLES consecutive idle cycles.
REQ-023 SHALL move ACTIVE->DRAIN when fetch_enable_i=0, with priority over idle expiry; a handshake completing in that same cycle is still valid.
REQ-024 SHALL, in DRAIN, move to SLEEP in the cycle after acc_busy_i=0 is sampled; DRAIN lasts at least 1 cycle and ignores req_valid_i.
REQ-025 SHALL size both counters to 8 bits; the counters never wrap because the legal parameter ranges bound them.
REQ-026 SHALL never assert acc_valid_o while clk_en_o=0.

Reset
REQ-027 SHALL, when rst_ni=0 at a clk_i edge, enter SLEEP and clear both counters, giving clk_en_o=0, busy_o=0, req_ready_o=0, acc_valid_o=0, state_o=0.
REQ-028 SHALL, when reset is asserted mid-operation in any state, abandon that operation with no drain, and SHALL resume from SLEEP.

Verification
REQ-029 Wake: with WAKE_CYCLES=2, in SLEEP, drive fetch_enable_i=1 and req_valid_i=1 at cycle 0 -> WAKE at cycles 1-2 with clk_en_o=1, ACTIVE at cycle 3, and acc_valid_o=1 and req_ready_o=acc_ready_i at cycle 3.
REQ-030 Idle gating: with IDLE_CYCLES=4, in ACTIVE, drive req_valid_i=0 and acc_busy_i=0 for 4 cycles -> SLEEP and clk_en_o=0 on the 5th cycle; a single req_valid_i pulse at the 3rd idle cycle restarts the count.
REQ-031 Drain: in ACTIVE with acc_busy_i=1, drop fetch_enable_i -> DRAIN with req_ready_o=0; hold acc_busy_i=1 for 5 more cycles, then 0 -> SLEEP in the following cycle.
REQ-032 Wake abort: drop fetch_enable_i during the 1st WAKE cycle -> SLEEP next cycle with no acc_valid_o pulse.
REQ-033 Reset: assert rst_ni=0 for 1 cycle while in ACTIVE with a pending request -> all outputs reach their reset values at the next edge; with req_valid_i held at 1, the block re-enters WAKE one cycle after reset is released.

Source files
------------

// File: rtl/redmule_pwr_ctrl.sv
// redmule_pwr_ctrl: clock-gate power controller sequencing accelerator wake, offload, idle gating and drain
module redmule_pwr_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       fetch_enable_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  output logic       acc_valid_o,
  input  logic       acc_ready_i,
  input  logic       acc_busy_i,
  output logic       clk_en_o,
  output logic       busy_o,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {SLEEP = 2'd0, WAKE = 2'd1, ACTIVE = 2'd2, DRAIN = 2'd3} state_e;
  state_e     state_q, state_d;
  logic [7:0] wake_cnt_q, wake_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       idle;
  // state and counter registers; reset abandons any operation without draining
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= SLEEP;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end
  // next-state and counter update
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    idle       = !req_valid_i && !acc_busy_i;
    case (state_q)
      SLEEP: if (fetch_enable_i && req_valid_i) begin
        state_d    = WAKE;
        wake_cnt_d = 8'(WAKE_CYCLES - 1);
      end
      WAKE: begin
        if (!fetch_enable_i) state_d = SLEEP;
        else if (wake_cnt_q == 8'd0) begin
          state_d    = ACTIVE;
          idle_cnt_d = '0;
        end else wake_cnt_d = wake_cnt_q - 8'd1;
      end
      ACTIVE: begin
        if (!fetch_enable_i) state_d = DRAIN;
        else if (idle && idle_cnt_q == 8'(IDLE_CYCLES - 1)) state_d = SLEEP;
        else idle_cnt_d = idle ? idle_cnt_q + 8'd1 : 8'd0;
      end
      DRAIN: if (!acc_busy_i) state_d = SLEEP;
      default: state_d = SLEEP;
    endcase
  end
  // output decode; handshake passes through only while ACTIVE, so never with the clock gated
  always_comb begin
    clk_en_o    = state_q != SLEEP;
    busy_o      = state_q != SLEEP;
    acc_valid_o = state_q == ACTIVE ? req_valid_i : 1'b0;
    req_ready_o = state_q == ACTIVE ? acc_ready_i : 1'b0;
    state_o     = state_q;
  end
endmodule

// File: tb/tb_redmule_pwr_ctrl.sv
// tb_redmule_pwr_ctrl: directed self-checking bench for redmule_pwr_ctrl
module tb_redmule_pwr_ctrl;
  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       fetch_enable_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       acc_ready_i = 1'b0;
  logic       acc_busy_i = 1'b0;
  logic       req_ready_o, acc_valid_o, clk_en_o, busy_o;
  logic [1:0] state_o;
  int checks = 0;
  int failures = 0;

  redmule_pwr_ctrl #(.WAKE_CYCLES(2), .IDLE_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .acc_valid_o(acc_valid_o),
    .acc_ready_i(acc_ready_i), .acc_busy_i(acc_busy_i), .clk_en_o(clk_en_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic ce, input logic av, input logic rr);
    chk({tag, "_state"}, 8'(state_o), 8'(st));
    chk({tag, "_clk_en"}, 8'(clk_en_o), 8'(ce));
    chk({tag, "_busy"}, 8'(busy_o), 8'(ce));
    chk({tag, "_acc_valid"}, 8'(acc_valid_o), 8'(av));
    chk({tag, "_req_ready"}, 8'(req_ready_o), 8'(rr));
  endtask

  initial begin
    tick(); tick();
    chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    tick();
    chk_all("sleep_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    req_valid_i = 1'b1; acc_ready_i = 1'b1; #1;
    chk_all("sleep_noen", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sleep_noen_stay", 8'(state_o), 8'd0);
    fetch_enable_i = 1'b1; #1;
    chk_all("wake_c0", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("wake_c1", 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("wake_c2", 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("active_c3", 2'd2, 1'b1, 1'b1, 1'b1);
    acc_ready_i = 1'b0; #1;
    chk("active_ready_follow", 8'(req_ready_o), 8'd0);
    req_valid_i = 1'b0; #1;
    chk("active_valid_follow", 8'(acc_valid_o), 8'd0);
    tick();
    tick();
    req_valid_i = 1'b1; #1;
    chk_all("idle_pulse", 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_count", 8'(state_o), 8'd2);
    end
    tick();
    chk_all("idle_gated", 2'd0, 1'b0, 1'b0, 1'b0);
    req_valid_i = 1'b1;
    tick();
    chk("abort_wake", 8'(state_o), 8'd1);
    fetch_enable_i = 1'b0; #1;
    chk("abort_no_valid", 8'(acc_valid_o), 8'd0);
    tick();
    chk_all("abort_sleep", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("abort_stay", 8'(state_o), 8'd0);
    fetch_enable_i = 1'b1;
    tick(); tick(); tick();
    chk("drain_active", 8'(state_o), 8'd2);
    acc_busy_i = 1'b1; acc_ready_i = 1'b1; fetch_enable_i = 1'b0; #1;
    chk("drain_last_handshake", 8'(req_ready_o), 8'd1);
    tick();
    chk_all("drain_enter", 2'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_hold", 8'(state_o), 8'd3);
    end
    acc_busy_i = 1'b0; #1;
    chk("drain_release", 8'(state_o), 8'd3);
    tick();
    chk_all("drain_sleep", 2'd0, 1'b0, 1'b0, 1'b0);
    fetch_enable_i = 1'b1; acc_ready_i = 1'b0;
    tick(); tick(); tick();
    chk("rst_active", 8'(state_o), 8'd2);
    rst_ni = 1'b0;
    tick();
    chk_all("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    tick();
    chk("rst_rewake", 8'(state_o), 8'd1);
    tick(); tick();
    chk("rst_reactive", 8'(state_o), 8'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
